// File: rtl/bcd_digit_timer.sv
// Cascaded BCD up/down timer with prescaled tick, start/stop/clear/load control and per-digit 7-segment drive.
// Optional LEADING_ZERO_BLANK_EN blanks leading-zero digits above digit 0.
module bcd_digit_timer #(
  parameter int CLK_DIV = 25,
  parameter int DIGITS  = 2
) (
  input  logic                clk_50MHz,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_bcd,
  input  logic                count_down,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic [8*DIGITS-1:0] seg,
  output logic                running,
  output logic                done,
  output logic                wrap
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

  state_t                state;
  logic [PW-1:0]         pre;
  logic [4*DIGITS-1:0]   inc_val;
  logic [4*DIGITS-1:0]   dec_val;
  logic [4*DIGITS-1:0]   sat_val;
  logic                  all_nines;
  logic                  cnt_zero;
  logic                  dec_zero;
  logic                  tick;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // Ripple chains: a digit moves only when every lower digit carries/borrows.
  always_comb begin
    inc_val   = bcd_out;
    dec_val   = bcd_out;
    sat_val   = load_bcd;
    all_nines = 1'b1;
    cnt_zero  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (all_nines)
        inc_val[4*i +: 4] = (bcd_out[4*i +: 4] == 4'd9) ? 4'd0 : bcd_out[4*i +: 4] + 4'd1;
      if (cnt_zero)
        dec_val[4*i +: 4] = (bcd_out[4*i +: 4] == 4'd0) ? 4'd9 : bcd_out[4*i +: 4] - 4'd1;
      all_nines = all_nines & (bcd_out[4*i +: 4] == 4'd9);
      cnt_zero  = cnt_zero & (bcd_out[4*i +: 4] == 4'd0);
      if (load_bcd[4*i +: 4] > 4'd9)
        sat_val[4*i +: 4] = 4'd9;
    end
    dec_zero = (dec_val == '0);
    tick     = (pre == PRE_LAST);
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      bcd_out <= '0;
      pre     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (clear) begin
        bcd_out <= '0;
        pre     <= '0;
        state   <= ST_IDLE;
        running <= 1'b0;
      end else if (load && state != ST_RUN) begin
        bcd_out <= sat_val;
        pre     <= '0;
        state   <= ST_IDLE;
        running <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_PAUSE: begin
            if (start && !stop && !(count_down && cnt_zero)) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            pre <= tick ? '0 : pre + PW'(1);
            if (stop) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
            // Expiry overrides a simultaneous stop.
            if (tick) begin
              if (count_down) begin
                bcd_out <= dec_val;
                if (dec_zero) begin
                  done    <= 1'b1;
                  state   <= ST_DONE;
                  running <= 1'b0;
                end
              end else begin
                bcd_out <= inc_val;
                wrap    <= all_nines;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic higher_nz;
    higher_nz = 1'b0;
`endif
    seg = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seg[8*i +: 8] = seg7(bcd_out[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (i != 0 && !higher_nz && bcd_out[4*i +: 4] == 4'd0)
        seg[8*i +: 8] = 8'hFF;
      higher_nz = higher_nz | (bcd_out[4*i +: 4] != 4'd0);
`endif
    end
  end

endmodule

// File: tb/tb_bcd_digit_timer.sv
// Directed + randomized bench for bcd_digit_timer against an integer-valued timer model.
module tb_bcd_digit_timer;
  localparam int CLK_DIV = 4;
  localparam int DIGITS  = 2;
  localparam int MAXV    = 10 ** DIGITS;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  logic                clk_50MHz = 1'b0;
  logic                reset, start, stop, clear, load, count_down;
  logic [4*DIGITS-1:0] load_bcd;
  logic [4*DIGITS-1:0] bcd_out;
  logic [8*DIGITS-1:0] seg;
  logic                running, done, wrap;

  int total = 0, passed = 0;
  int m_st, m_cnt, m_pre;
  bit m_run, m_done, m_wrap;

  bcd_digit_timer #(.CLK_DIV(CLK_DIV), .DIGITS(DIGITS)) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .load(load), .load_bcd(load_bcd), .count_down(count_down), .bcd_out(bcd_out),
    .seg(seg), .running(running), .done(done), .wrap(wrap)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [8*DIGITS-1:0] exp_seg(input int v);
    logic [8*DIGITS-1:0] r;
    int p;
    r = '1;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[8*i +: 8] = SEG_TAB[(v / p) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < p) r[8*i +: 8] = 8'hFF;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int load_val(input logic [4*DIGITS-1:0] v);
    int r, p, nib;
    r = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      nib = int'(v[4*i +: 4]);
      r = r + ((nib > 9) ? 9 : nib) * p;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_cnt = 0; m_pre = 0;
    m_run = 0; m_done = 0; m_wrap = 0;
  endtask

  // One clock of the timer in terms of a decimal count value.
  task automatic model_step();
    m_done = 0;
    m_wrap = 0;
    if (clear) begin
      m_cnt = 0; m_pre = 0; m_st = S_IDLE;
    end else if (load && m_st != S_RUN) begin
      m_cnt = load_val(load_bcd); m_pre = 0; m_st = S_IDLE;
    end else if (m_st == S_IDLE || m_st == S_PAUSE) begin
      if (start && !stop && !(count_down && m_cnt == 0)) m_st = S_RUN;
    end else if (m_st == S_RUN) begin
      if (stop) m_st = S_PAUSE;
      if (m_pre == CLK_DIV - 1) begin
        m_pre = 0;
        if (count_down) begin
          m_cnt = (m_cnt + MAXV - 1) % MAXV;
          if (m_cnt == 0) begin m_done = 1; m_st = S_DONE; end
        end else begin
          m_wrap = (m_cnt == MAXV - 1);
          m_cnt = (m_cnt + 1) % MAXV;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    m_run = (m_st == S_RUN);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    check("bcd_out", 64'(bcd_out), 64'(to_bcd(m_cnt)));
    check("seg", 64'(seg), 64'(exp_seg(m_cnt)));
    check("running", 64'(running), 64'(m_run));
    check("done", 64'(done), 64'(m_done));
    check("wrap", 64'(wrap), 64'(m_wrap));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk_50MHz);
    #1;
    check_all();
  endtask

  initial begin
    int nwrap, ndone, k;
    reset = 1; start = 0; stop = 0; clear = 0; load = 0; count_down = 0; load_bcd = '0;
    model_reset();
    @(posedge clk_50MHz); #1;
    check_all();
    reset = 0;
    cyc();

    // Up count through a full rollover.
    start = 1; cyc(); start = 0;
    nwrap = 0;
    repeat (401) begin cyc(); if (wrap) nwrap++; end
    check("wrap_once", 64'(nwrap), 64'd1);
    check("after_roll", 64'(bcd_out), 64'h00);
    repeat (147) cyc();
    check("count_37", 64'(bcd_out), 64'h37);

    // Asynchronous reset mid-cycle.
    reset = 1; #1;
    check("arst_bcd", 64'(bcd_out), 64'h00);
    check("arst_run", 64'(running), 64'd0);
    check("arst_seg", 64'(seg), 64'hC0C0);
    model_reset();
    #2 reset = 0;
    cyc();

    // Countdown from 12 to expiry, then start at zero is ignored.
    load_bcd = 8'h12; load = 1; cyc(); load = 0;
    count_down = 1; start = 1; cyc(); start = 0;
    ndone = 0;
    repeat (52) begin cyc(); if (done) ndone++; end
    check("done_once", 64'(ndone), 64'd1);
    check("down_zero", 64'(bcd_out), 64'h00);
    check("down_stopped", 64'(running), 64'd0);
    start = 1; cyc(); start = 0;
    repeat (10) begin cyc(); if (done) ndone++; end
    check("no_redone", 64'(ndone), 64'd1);
    check("still_zero", 64'(bcd_out), 64'h00);

    // Pause keeps the prescaler phase.
    clear = 1; cyc(); clear = 0;
    count_down = 0; start = 1; cyc(); start = 0;
    repeat (8) cyc();
    stop = 1; cyc(); stop = 0;
    repeat (20) cyc();
    check("paused", 64'(bcd_out), 64'h02);
    start = 1; cyc(); start = 0;
    k = 0;
    while (k < 10 && bcd_out == 8'h02) begin cyc(); k++; end
    check("resume_lat", 64'(k), 64'd3);

    // Control priority.
    repeat (2) cyc();
    clear = 1; load = 1; start = 1; load_bcd = 8'h55; cyc();
    clear = 0; load = 0; start = 0;
    check("prio_clear", 64'(bcd_out), 64'h00);
    check("prio_idle", 64'(running), 64'd0);
    start = 1; cyc(); start = 0;
    stop = 1; cyc(); stop = 0;
    load_bcd = 8'hAF; load = 1; cyc(); load = 0;
    check("load_sat", 64'(bcd_out), 64'h99);

    // Random control traffic.
    for (int n = 0; n < 3000; n++) begin
      clear = ($urandom_range(0, 99) < 2);
      load  = ($urandom_range(0, 99) < 4);
      stop  = ($urandom_range(0, 99) < 5);
      start = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 199) == 0) count_down = ~count_down;
      load_bcd = (4*DIGITS)'($urandom);
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
